// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single memory controller.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// A WAIT phase that sees no memory ready within TIMEOUT_CYCLES cycles is
// closed with a zero-data response and a one-cycle o_err pulse.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when defined, contention is
// resolved round-robin; when undefined, port 0 always wins contention.

package mci_pkg;
    typedef struct packed {
        logic         valid;
        logic         rw;      // 1 = write, 0 = read
        logic [31:0]  addr;
        logic [127:0] data;
    } mci_request_t;

    typedef struct packed {
        logic         ready;
        logic [127:0] data;
    } mci_response_t;
endpackage

module mem_arbiter
    import mci_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  mci_request_t  p0_req,
    output mci_response_t p0_res,
    input  mci_request_t  p1_req,
    output mci_response_t p1_res,
    output mci_request_t  mem_req,
    input  mci_response_t mem_res,
    output logic          o_busy,
    output logic          o_grant,
    output logic          o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Last WAIT count value before the transaction is declared timed out.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    mci_request_t  mem_req_q, mem_req_d;
    mci_response_t p0_res_q, p0_res_d;
    mci_response_t p1_res_q, p1_res_d;
    logic          busy_q, busy_d;
    logic          grant_q, grant_d;
    logic          err_q, err_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;

    logic          any_req_s;
    logic          win_port_s;
    mci_request_t  win_req_s;
    logic          timeout_s;
    logic [127:0]  rsp_data_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_grant_q, last_grant_d;
`endif

    assign any_req_s = p0_req.valid | p1_req.valid;
    assign timeout_s = (wait_cnt_q == WAIT_LAST);
    assign win_req_s = win_port_s ? p1_req : p0_req;

    // Arbitration: pick the winning port among the currently valid requests.
    always_comb begin
        win_port_s = 1'b0;
        if (p0_req.valid && p1_req.valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_port_s = ~last_grant_q;
`else
            win_port_s = 1'b0;
`endif
        end else if (p1_req.valid) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory ready is only honoured while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_res.ready || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; every output leaves the block from a flop.
    always_comb begin
        mem_req_d       = mem_req_q;
        mem_req_d.valid = (state_q == ST_IDLE) && any_req_s;
        p0_res_d        = p0_res_q;
        p0_res_d.ready  = 1'b0;
        p1_res_d        = p1_res_q;
        p1_res_d.ready  = 1'b0;
        grant_d         = grant_q;
        err_d           = 1'b0;
        busy_d          = (state_d != ST_IDLE);
        wait_cnt_d      = 16'd0;
        rsp_data_s      = 128'd0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    mem_req_d.rw   = win_req_s.rw;
                    mem_req_d.addr = win_req_s.addr;
                    mem_req_d.data = win_req_s.data;
                    grant_d        = win_port_s;
                end else begin
                    grant_d        = grant_q;
                end
            end
            ST_WAIT: begin
                if (mem_res.ready || timeout_s) begin
                    // Ready wins over a timeout landing in the same cycle.
                    rsp_data_s = mem_res.ready ? mem_res.data : 128'd0;
                    err_d      = ~mem_res.ready;
                    if (grant_q) begin
                        p1_res_d.ready = 1'b1;
                        p1_res_d.data  = rsp_data_s;
                    end else begin
                        p0_res_d.ready = 1'b1;
                        p0_res_d.data  = rsp_data_s;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                wait_cnt_d = 16'd0;
            end
        endcase
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: remember the owner of every completed transaction.
    always_comb begin
        if (state_q == ST_RESP) begin
            last_grant_d = grant_q;
        end else begin
            last_grant_d = last_grant_q;
        end
    end
`endif

    // Output and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_req_q    <= '0;
            p0_res_q     <= '0;
            p1_res_q     <= '0;
            busy_q       <= 1'b0;
            grant_q      <= 1'b0;
            err_q        <= 1'b0;
            wait_cnt_q   <= 16'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Pretend port 1 went last so port 0 wins the first contention.
            last_grant_q <= 1'b1;
`endif
        end else begin
            mem_req_q    <= mem_req_d;
            p0_res_q     <= p0_res_d;
            p1_res_q     <= p1_res_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_req = mem_req_q;
    assign p0_res  = p0_res_q;
    assign p1_res  = p1_res_q;
    assign o_busy  = busy_q;
    assign o_grant = grant_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural memory, scoreboard of expected
// responses, directed read/write, timeout, reset, stray-ready and contention.
module tb_mem_arbiter;
    import mci_pkg::*;

    localparam int TO = 8;

    typedef struct {
        logic         port;
        logic [127:0] data;
        logic         err;
        logic         chk_data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    mci_request_t  p0_req, p1_req, mem_req;
    mci_response_t p0_res, p1_res, mem_res;
    logic          busy, grant, err;
    logic          mm_ready, stray_ready;
    logic [127:0]  mm_data;

    int            err_cnt = 0;
    int            chk_cnt = 0;
    exp_t          sb_q[$];

    int            mm_delay;
    bit            stray_issue;
    int            issue_cnt;
    int            pend;
    logic [31:0]   pend_addr;
    logic          last_rw;
    logic [31:0]   last_addr;
    logic [127:0]  last_data;
    logic [127:0]  mm_mem  [logic [31:0]];
    logic [127:0]  exp_mem [logic [31:0]];

    localparam logic [127:0] WDATA = 128'h11223344_55667788_99AABBCC_DDEEFF00;

    assign mem_res = {mm_ready | stray_ready, mm_data};

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .p0_req  (p0_req),
        .p0_res  (p0_res),
        .p1_req  (p1_req),
        .p1_res  (p1_res),
        .mem_req (mem_req),
        .mem_res (mem_res),
        .o_busy  (busy),
        .o_grant (grant),
        .o_err   (err)
    );

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] default_blk(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a, ~a, a + 32'h1357_9BDF};
    endfunction

    function automatic logic [127:0] exp_read(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : default_blk(a);
    endfunction

    // Behavioural memory: answers each issued request mm_delay cycles later.
    initial begin
        mm_ready  = 1'b0;
        mm_data   = 128'd0;
        pend      = 0;
        pend_addr = 32'd0;
        issue_cnt = 0;
        forever begin
            @(negedge clk);
            mm_ready = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mm_ready = 1'b1;
                    mm_data  = mm_mem.exists(pend_addr) ? mm_mem[pend_addr] : default_blk(pend_addr);
                end
            end
            if (mem_req.valid) begin
                issue_cnt++;
                last_rw   = mem_req.rw;
                last_addr = mem_req.addr;
                last_data = mem_req.data;
                if (mem_req.rw) mm_mem[mem_req.addr] = mem_req.data;
                pend_addr = mem_req.addr;
                pend      = mm_delay;
                if (stray_issue) begin
                    mm_ready = 1'b1;
                    mm_data  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
                end
            end
        end
    end

    // Response monitor: every ready pulse is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p0_res.ready || p1_res.ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_ready", {p1_res.ready, p0_res.ready}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    check_val("rsp_port", {p1_res.ready, p0_res.ready}, e.port ? 2'b10 : 2'b01);
                    check_val("rsp_grant", grant, e.port);
                    check_val("rsp_err", err, e.err);
                    if (e.chk_data) check_val("rsp_data", e.port ? p1_res.data : p0_res.data, e.data);
                end
            end else if (err) begin
                check_val("err_without_ready", err, 1'b0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_grant"}, grant, 1'b0);
        check_val({tag, "_err"}, err, 1'b0);
        check_val({tag, "_mem_req"}, mem_req, 162'd0);
        check_val({tag, "_p0_res"}, p0_res, 129'd0);
        check_val({tag, "_p1_res"}, p1_res, 129'd0);
    endtask

    // One complete transaction on one port; lat_exp counts negedges from drive to pulse.
    task automatic do_txn(input logic port, input logic rw, input logic [31:0] addr,
                          input logic [127:0] wdata, input int lat_exp);
        exp_t         e;
        mci_request_t r;
        int           n;
        int           iss0;
        bit           seen;
        @(negedge clk);
        r          = '{valid: 1'b1, rw: rw, addr: addr, data: wdata};
        e.port     = port;
        e.err      = (mm_delay == 0);
        e.chk_data = ~rw;
        e.data     = e.err ? 128'd0 : exp_read(addr);
        if (rw) exp_mem[addr] = wdata;
        sb_q.push_back(e);
        iss0 = issue_cnt;
        if (port) p1_req = r; else p0_req = r;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = port ? p1_res.ready : p0_res.ready;
        end
        check_val("latency", n, lat_exp);
        check_val("hold_addr", mem_req.addr, addr);
        check_val("hold_valid", mem_req.valid, 1'b0);
        if (port) p1_req.valid = 1'b0; else p0_req.valid = 1'b0;
        check_val("issue_count", issue_cnt - iss0, 1);
        check_val("issue_rw", last_rw, rw);
        check_val("issue_addr", last_addr, addr);
    endtask

    initial begin
        logic [3:0] seq;
        int         n;
        bit         seen;
        exp_t       e;

        rst_n       = 1'b0;
        p0_req      = '0;
        p1_req      = '0;
        stray_ready = 1'b0;
        stray_issue = 1'b0;
        mm_delay    = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single read, memory answers one cycle after ISSUE.
        do_txn(1'b0, 1'b0, 32'h0000_0040, 128'd0, 3);

        // Write then read back on port 1.
        do_txn(1'b1, 1'b1, 32'h0000_0100, WDATA, 3);
        check_val("write_data", last_data, WDATA);
        do_txn(1'b1, 1'b0, 32'h0000_0100, 128'd0, 3);

        // Slower memory, and ready arriving in the very last WAIT cycle.
        mm_delay = 5;
        do_txn(1'b0, 1'b0, 32'h0000_0200, 128'd0, 7);
        mm_delay = TO;
        do_txn(1'b0, 1'b0, 32'h0000_0210, 128'd0, TO + 2);
        check_val("p1_data_hold", p1_res.data, WDATA);

        // Timeout: memory never answers.
        mm_delay = 0;
        do_txn(1'b0, 1'b0, 32'h0000_0300, 128'd0, TO + 2);
        @(negedge clk);
        check_val("timeout_idle_busy", busy, 1'b0);
        check_val("timeout_p0_data", p0_res.data, 128'd0);

        // Stray ready in IDLE, then in ISSUE.
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        @(negedge clk);
        check_val("stray_idle_busy", busy, 1'b0);
        mm_delay    = 3;
        stray_issue = 1'b1;
        do_txn(1'b1, 1'b0, 32'h0000_0400, 128'd0, 5);
        stray_issue = 1'b0;

        // Reset in the middle of WAIT on port 1, late ready afterwards.
        mm_delay = 0;
        @(negedge clk);
        p1_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0500, data: 128'd0};
        repeat (3) @(negedge clk);
        check_val("pre_reset_busy", busy, 1'b1);
        rst_n        = 1'b0;
        p1_req.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");

        // Contention with both ports holding valid.
        mm_delay = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        seq = 4'b1010;
`else
        seq = 4'b1000;
`endif
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e.port     = seq[k];
            e.err      = 1'b0;
            e.chk_data = 1'b1;
            e.data     = exp_read(seq[k] ? 32'h0000_0600 : 32'h0000_0580);
            sb_q.push_back(e);
        end
        p0_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0580, data: 128'd0};
        p1_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h0000_0600, data: 128'd0};
        for (int k = 0; k < 4; k++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                n++;
                seen = p0_res.ready | p1_res.ready;
            end
            check_val("cont_grant", grant, seq[k]);
            check_val("cont_latency", n, (k == 0) ? 3 : 4);
`ifndef MEM_ARB_ROUND_ROBIN_EN
            if (k == 2) p0_req.valid = 1'b0;
`endif
        end
        p0_req.valid = 1'b0;
        p1_req.valid = 1'b0;

        repeat (4) @(negedge clk);
        check_val("final_busy", busy, 1'b0);
        check_val("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
